// File: rtl/dac_spi_writer.sv
`default_nettype none
// ============================================================================
// dac_spi_writer : dual-channel 12-bit serial DAC writer (MCP4922-style frames)
//                  with a shared LDAC strobe. Optional macro: DAC_SPI_CLAMP_EN.
// Revision 1.0
// ============================================================================
module dac_spi_writer #(
   parameter int CLK_DIV     = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int LDAC_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  run,
   input  logic [15:0] sample_a,
   input  logic [15:0] sample_b,
   output logic        cs_n,
   output logic        sck,
   output logic        sdi,
   output logic        ldac_n,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam logic [15:0] c_DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] c_GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] c_LDAC_LAST = 16'(LDAC_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4,
      S_LDAC  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [3:0]  r_bit;
   logic        r_hi;
   logic        r_ch;
   logic [15:0] r_sa;
   logic [15:0] r_sb;
   logic [1:0]  r_run;
   logic        r_ovr_req;

   logic [11:0] w_code_a;
   logic [11:0] w_code_b;
   logic [11:0] w_code;
   logic        w_en;
   logic [15:0] w_frame;

   function automatic logic [11:0] f_code(input logic [15:0] s);
`ifdef DAC_SPI_CLAMP_EN
      logic [16:0] sum;
      sum = {s[15], s} + 17'd2048;
      if (sum[16])
         f_code = 12'd0;
      else if (sum[15:12] != 4'd0)
         f_code = 12'hFFF;
      else
         f_code = sum[11:0];
`else
      // Low 12 bits of (s + 2048) are all that survive the modulo-4096 wrap.
      f_code = s[11:0] + 12'd2048;
`endif
   endfunction

   assign w_code_a = f_code(r_sa);
   assign w_code_b = f_code(r_sb);
   assign w_code   = r_ch ? w_code_b : w_code_a;
   assign w_en     = r_ch ? r_run[1] : r_run[0];
   assign w_frame  = {r_ch, 1'b0, 1'b1, w_en, (w_en ? w_code : 12'd0)};

   // Outputs are registered from the current state, so pins trail the state by one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_bit     <= 4'd0;
         r_hi      <= 1'b0;
         r_ch      <= 1'b0;
         r_sa      <= 16'd0;
         r_sb      <= 16'd0;
         r_run     <= 2'b00;
         r_ovr_req <= 1'b0;
         cs_n      <= 1'b1;
         sck       <= 1'b0;
         sdi       <= 1'b0;
         ldac_n    <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         r_ovr_req <= start && (r_state != S_IDLE);
         overrun   <= r_ovr_req;
         done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               cs_n   <= 1'b1;
               sck    <= 1'b0;
               sdi    <= 1'b0;
               ldac_n <= 1'b1;
               busy   <= 1'b0;
               if (start) begin
                  r_sa    <= sample_a;
                  r_sb    <= sample_b;
                  r_run   <= run;
                  r_ch    <= 1'b0;
                  r_cnt   <= 16'd0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               cs_n   <= 1'b0;
               sck    <= 1'b0;
               sdi    <= w_frame[15];
               ldac_n <= 1'b1;
               busy   <= 1'b1;
               if (r_cnt == c_DIV_LAST) begin
                  r_cnt   <= 16'd0;
                  r_bit   <= 4'd0;
                  r_hi    <= 1'b0;
                  r_state <= S_SHIFT;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_SHIFT: begin
               cs_n <= 1'b0;
               busy <= 1'b1;
               sck  <= r_hi;
               if (!r_hi)
                  sdi <= w_frame[4'd15 - r_bit];
               if (r_cnt == c_DIV_LAST) begin
                  r_cnt <= 16'd0;
                  r_hi  <= !r_hi;
                  if (r_hi) begin
                     if (r_bit == 4'd15)
                        r_state <= S_HOLD;
                     else
                        r_bit <= r_bit + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_HOLD: begin
               cs_n <= 1'b0;
               sck  <= 1'b0;
               busy <= 1'b1;
               if (r_cnt == c_DIV_LAST) begin
                  r_cnt   <= 16'd0;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_GAP: begin
               cs_n <= 1'b1;
               sck  <= 1'b0;
               sdi  <= 1'b0;
               busy <= 1'b1;
               if (r_cnt == c_GAP_LAST) begin
                  r_cnt <= 16'd0;
                  if (!r_ch) begin
                     r_ch    <= 1'b1;
                     r_state <= S_SETUP;
                  end else begin
                     r_state <= S_LDAC;
                  end
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_LDAC: begin
               cs_n   <= 1'b1;
               sck    <= 1'b0;
               sdi    <= 1'b0;
               ldac_n <= 1'b0;
               busy   <= 1'b1;
               if (r_cnt == c_LDAC_LAST) begin
                  r_cnt   <= 16'd0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               ldac_n  <= 1'b1;
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_writer.sv
`default_nettype none
// ============================================================================
// tb_dac_spi_writer : randomized self-checking bench for dac_spi_writer
// Revision 1.0
// ============================================================================
module tb_dac_spi_writer;

   localparam int CLK_DIV     = 4;
   localparam int GAP_CYCLES  = 2;
   localparam int LDAC_CYCLES = 2;
   localparam int EXP_DONE    = 1 + 2 * (34 * CLK_DIV + GAP_CYCLES) + LDAC_CYCLES;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  run;
   logic [15:0] sample_a;
   logic [15:0] sample_b;
   logic        cs_n, sck, sdi, ldac_n, busy, done, overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   dac_spi_writer #(
      .CLK_DIV     (CLK_DIV),
      .GAP_CYCLES  (GAP_CYCLES),
      .LDAC_CYCLES (LDAC_CYCLES)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .run      (run),
      .sample_a (sample_a),
      .sample_b (sample_b),
      .cs_n     (cs_n),
      .sck      (sck),
      .sdi      (sdi),
      .ldac_n   (ldac_n),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: decodes frames on sck rising edges, counts strobes.
   logic [15:0] fr_data [256];
   int          fr_bits [256];
   int          nfr     = 0;
   int          ldac_lo = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          ovr_cnt = 0;
   int          ovr_cyc = 0;
   int          glitch  = 0;
   logic        prev_cs  = 1'b1;
   logic        prev_sck = 1'b0;
   logic        hi_sdi   = 1'b0;
   logic [15:0] shreg    = 16'd0;
   int          bitcnt   = 0;

   always @(posedge clk) begin
      #1;
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
         shreg  = 16'd0;
         bitcnt = 0;
      end
      if (cs_n === 1'b0 && sck === 1'b1 && prev_sck === 1'b0) begin
         shreg  = {shreg[14:0], sdi};
         bitcnt = bitcnt + 1;
         hi_sdi = sdi;
      end else if (sck === 1'b1 && prev_sck === 1'b1 && sdi !== hi_sdi) begin
         glitch = glitch + 1;
      end
      if (prev_cs === 1'b0 && cs_n === 1'b1) begin
         fr_data[nfr % 256] = shreg;
         fr_bits[nfr % 256] = bitcnt;
         nfr = nfr + 1;
      end
      if (ldac_n === 1'b0) ldac_lo = ldac_lo + 1;
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (overrun === 1'b1) begin
         ovr_cnt = ovr_cnt + 1;
         ovr_cyc = cyc;
      end
      prev_cs  = cs_n;
      prev_sck = sck;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: DAC command word built from plain integer arithmetic.
   function automatic int exp_frame(input int ch, input int s, input int en);
      int sum;
      int code;
      sum = s + 2048;
`ifdef DAC_SPI_CLAMP_EN
      if (sum < 0)         code = 0;
      else if (sum > 4095) code = 4095;
      else                 code = sum;
`else
      code = ((sum % 4096) + 4096) % 4096;
`endif
      if (en == 0) code = 0;
      return ch * 32768 + 8192 + en * 4096 + code;
   endfunction

   task automatic xfer(input string name, input int a, input int b, input int r, input int ovr_off);
      int rd, l0, d0, o0, g0, t0, got_done, dcyc;
      rd = nfr; l0 = ldac_lo; d0 = done_cnt; o0 = ovr_cnt; g0 = glitch;
      got_done = 0;
      dcyc     = -1;
      sample_a = 16'(a);
      sample_b = 16'(b);
      run      = 2'(r);
      start    = 1'b1;
      t0       = cyc + 1;
      for (int i = 0; i < EXP_DONE + 50 && got_done == 0; i++) begin
         @(negedge clk);
         start    = (ovr_off > 0) && (cyc + 1 == t0 + ovr_off);
         sample_a = 16'($urandom);
         sample_b = 16'($urandom);
         run      = 2'($urandom);
         if (cyc == t0 + 1)
            chk({name, "/busy_cs_edge1"}, 32'({busy, cs_n}), 32'b10);
         if (done === 1'b1) begin
            got_done = 1;
            dcyc     = cyc - t0;
            chk({name, "/busy_at_done"}, 32'(busy), 32'd0);
         end
      end
      start = 1'b0;
      chk({name, "/done_edge"}, dcyc, EXP_DONE);
      chk({name, "/done_count"}, done_cnt - d0, 1);
      chk({name, "/n_frames"}, nfr - rd, 2);
      chk({name, "/frame_a"}, 32'(fr_data[rd % 256]), exp_frame(0, a, r % 2));
      chk({name, "/bits_a"}, fr_bits[rd % 256], 16);
      chk({name, "/frame_b"}, 32'(fr_data[(rd + 1) % 256]), exp_frame(1, b, r / 2));
      chk({name, "/bits_b"}, fr_bits[(rd + 1) % 256], 16);
      chk({name, "/ldac_low"}, ldac_lo - l0, LDAC_CYCLES);
      chk({name, "/sdi_glitch"}, glitch - g0, 0);
      chk({name, "/overrun_cnt"}, ovr_cnt - o0, (ovr_off > 0) ? 1 : 0);
      if (ovr_off > 0)
         chk({name, "/overrun_edge"}, ovr_cyc - t0, ovr_off + 1);
   endtask

   task automatic xfer_reset(input int rst_off);
      int l0, d0, t0;
      l0 = ldac_lo; d0 = done_cnt;
      sample_a = 16'($urandom);
      sample_b = 16'($urandom);
      run      = 2'b11;
      start    = 1'b1;
      t0       = cyc + 1;
      for (int i = 0; i < rst_off + 300; i++) begin
         @(negedge clk);
         start = 1'b0;
         reset = (cyc + 1 == t0 + rst_off);
         if (cyc == t0 + rst_off + 1)
            chk("rst_mid/idle_outputs", 32'({cs_n, sck, sdi, ldac_n, busy, done, overrun}), 32'b1001000);
      end
      reset = 1'b0;
      chk("rst_mid/ldac_low", ldac_lo - l0, 0);
      chk("rst_mid/done_count", done_cnt - d0, 0);
   endtask

   initial begin
      int a, b, r;
      reset    = 1'b1;
      start    = 1'b0;
      run      = 2'b00;
      sample_a = 16'd0;
      sample_b = 16'd0;
      repeat (3) @(negedge clk);
      chk("reset_state", 32'({cs_n, sck, sdi, ldac_n, busy, done, overrun}), 32'b1001000);
      reset = 1'b0;
      @(negedge clk);

      xfer("zero",    0,     0,     3, 0);
      xfer("pm2047",  -2047, 2047,  3, 0);
      xfer("pm3000",  3000,  -3000, 3, 0);
      xfer("run01",   100,   500,   1, 0);
      xfer("overrun", 1234,  -567,  3, 50);
      xfer("b2b",     -2048, 2047,  2, 0);
      xfer_reset(100);
      xfer("post_rst", 42,   -42,   3, 0);

      for (int k = 0; k < 12; k++) begin
         a = int'($urandom_range(65535)) - 32768;
         b = (k % 2 == 0) ? int'($urandom_range(8191)) - 4096 : int'($urandom_range(65535)) - 32768;
         r = int'($urandom_range(3));
         xfer($sformatf("rand%0d", k), a, b, r, (k % 4 == 3) ? int'($urandom_range(200, 10)) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dac_spi_writer.md
# dac_spi_writer

Dual-channel SPI transmitter that consumes the signed sample pair produced by the waveform generators (channels A and B) and writes it to a 12-bit dual-channel serial DAC (MCP4922-class command format). On each accepted `start` strobe it converts both samples to offset-binary 12-bit codes, shifts out one 16-bit frame per channel, then pulses `ldac_n` so both DAC outputs update together. It sits between the waveform generator outputs and the board-level DAC pins.

## Interface
- `CLK_DIV`, 4: SCK half-period in `clk` cycles (≥1)
- `GAP_CYCLES`, 2: `cs_n` high time between channel A and channel B frames (≥1)
- `LDAC_CYCLES`, 2: `ldac_n` low pulse width (≥1)

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a DAC update; sampled only in IDLE
- `run`  in  2  per-channel enable, bit0 = A, bit1 = B; latched with samples
- `sample_a`  in  16  signed sample, channel A (nominal ±2047)
- `sample_b`  in  16  signed sample, channel B
- `cs_n`  out  1  DAC chip select, active low
- `sck`  out  1  SPI clock, idle low, DAC samples on rising edge
- `sdi`  out  1  serial data, MSB first
- `ldac_n`  out  1  DAC latch strobe, active low
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse, transfer complete
- `overrun`  out  1  one-cycle pulse, `start` seen while busy

## Operation
- States: IDLE → CS_SETUP → SHIFT → CS_HOLD → GAP → (CS_SETUP for B | LDAC) → DONE → IDLE.
- IDLE: `start`=1 latches `sample_a`, `sample_b`, `run`; channel pointer = A; next state CS_SETUP.
- Code conversion per channel: 17-bit signed sum = sample + 2048; 12-bit code derived per Configuration.
- Frame (16 b): [15] channel (0=A, 1=B), [14] BUF=0, [13] GA_n=1, [12] SHDN_n=latched run bit, [11:0] code; code forced to 0 when run bit is 0.
- CS_SETUP: `cs_n`=0, `sck`=0, `sdi`=frame[15], CLK_DIV cycles.
- SHIFT: 16 bits; each bit = CLK_DIV cycles `sck` low then CLK_DIV cycles `sck` high; `sdi` updates only at the start of a low phase (never while `sck` high).
- CS_HOLD: `sck`=0, `cs_n`=0 for CLK_DIV cycles; then `cs_n`=1.
- GAP: `cs_n`=1, `sdi`=0 for GAP_CYCLES; after A go to CS_SETUP with channel B, after B go to LDAC.
- LDAC: `ldac_n`=0 for LDAC_CYCLES; DONE: `done`=1 one cycle, `busy`=0 in that cycle, return to IDLE.
- `start` while not in IDLE: ignored, no queuing; `overrun` pulses the following cycle. `start` in the DONE cycle is also an overrun.

## Timing
- Reset values: `cs_n`=1, `sck`=0, `sdi`=0, `ldac_n`=1, `busy`=0, `done`=0, `overrun`=0, state IDLE; registers take these values at the first `clk` edge with `reset`=1.
- Reset mid-transfer: outputs return to reset values on the next edge; no partial LDAC pulse; no `done`.
- `start` sampled at edge 0 → `busy`=1 and `cs_n`=0 from edge 1.
- Per-channel frame = 34·CLK_DIV cycles with `cs_n` low.
- `done` at edge 1 + 2·(34·CLK_DIV + GAP_CYCLES) + LDAC_CYCLES; defaults → edge 279.
- Next `start` is accepted in the cycle after `done` (IDLE).
- Latched samples are stable for the whole transfer; input changes after edge 0 do not affect frames.

## Configuration
- `DAC_SPI_CLAMP_EN` defined: code saturates — sum < 0 → 0, sum > 4095 → 4095, else sum[11:0].
- Not defined: code = sum[11:0] (modulo-4096 wrap, no comparators).

## Test plan
- Reset, `start` with A=0, B=0, run=2'b11 → frames 0x3800 then 0xB800 MSB-first, `ldac_n` low 2 cycles, `done` at edge 279.
- A=−2047, B=2047, run=2'b11 → codes 0x001/0xFFF, frames 0x3001, 0xBFFF; sdi stable across every `sck` high phase.
- A=3000, B=−3000 → with `DAC_SPI_CLAMP_EN`: 0x3FFF, 0xB000; without: 0x33B8 (952), 0xBC48 (3144).
- run=2'b01, A=100, B=500 → A frame 0x3864, B frame 0xA000 (SHDN_n=0, code 0).
- `start` pulsed at edges 0 and 50 → second ignored, `overrun` at edge 51, single `done` at 279; `start` at 280 begins new transfer.
- `reset` asserted at edge 100 of a transfer → `cs_n`=1, `sck`=0, `busy`=0 from edge 101, no `ldac_n` pulse or `done`; subsequent `start` completes normally.
